// File: rtl/ramblock_fifo_pkg.sv
// Shared sizing and strobe-level constants for the RAM-block FIFO controller.
package ramblock_fifo_pkg;

    localparam int AW         = 8;
    localparam int DW         = 9;
    localparam int DEPTH      = 2 ** AW;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Occupancy value reported when every RAM word holds unread data.
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    // RAM strobes are active-low.
    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/ramblock_fifo_flags.sv
// Occupancy status decode: full/empty plus threshold compare, purely combinational.
module ramblock_fifo_flags
    import ramblock_fifo_pkg::*;
(
    input  logic [AW:0] count,
    input  logic [AW:0] th,
    output logic        full,
    output logic        empty,
    output logic        eqth,
    output logic        geqth
);

    // Decode all status flags from the current occupancy.
    always_comb begin
        full  = 1'b0;
        empty = 1'b0;
        eqth  = 1'b0;
        geqth = 1'b0;
        if (count == DEPTH_CNT) begin
            full = 1'b1;
        end else begin
            full = 1'b0;
        end
        if (count == {(AW + 1){1'b0}}) begin
            empty = 1'b1;
        end else begin
            empty = 1'b0;
        end
        eqth  = (count == th);
        geqth = (count >= th);
    end

endmodule

// File: rtl/ramblock_fifo_ctrl.sv
// Single-clock FIFO controller sequencing a 256x9 synchronous RAM block.
// Write and read strobes both leave through one register stage so a word
// written in cycle k+1 is visible to a read strobed in cycle k+2.
module ramblock_fifo_ctrl
    import ramblock_fifo_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          CLKS,
    input  logic          RSTB,
    input  logic          PUSH,
    input  logic [DW-1:0] PUSH_D,
    input  logic          POP,
    input  logic          FLUSH,
    input  logic [AW:0]   TH,
    output logic [AW-1:0] WADDR,
    output logic          WRB,
    output logic [DW-1:0] DIn,
    output logic [AW-1:0] RADDR,
    output logic          RDB,
    input  logic [DW-1:0] DO,
    output logic [DW-1:0] POP_D,
    output logic          POP_VLD,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          EQTH,
    output logic          GEQTH,
    output logic          OVF,
    output logic          UDF
);

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic [AW-1:0] waddr_r;
    logic [AW-1:0] raddr_r;
    logic [DW-1:0] din_r;
    logic          wrb_r;
    logic          rdb_r;
    logic          ovf_r;
    logic          udf_r;
    logic [RD_LAT:0] vld_pipe_r;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    ramblock_fifo_flags u_flags (
        .count (count_r),
        .th    (TH),
        .full  (full_s),
        .empty (empty_s),
        .eqth  (EQTH),
        .geqth (GEQTH)
    );

    // Accept decisions use the flags of the registered state before the edge.
    always_comb begin
        push_ok_s   = PUSH & ~full_s;
        pop_ok_s    = POP & ~empty_s;
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge CLKS) begin
        if (!RSTB || FLUSH) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + 1'b1;
            if (pop_ok_s)  rptr_r <= rptr_r + 1'b1;
            count_r <= count_nxt_s;
        end
    end

    // Write strobe path: one-cycle WRB pulse with registered address/data.
    always_ff @(posedge CLKS) begin
        if (!RSTB) begin
            wrb_r   <= STB_OFF;
            waddr_r <= '0;
            din_r   <= '0;
        end else if (FLUSH) begin
            wrb_r <= STB_OFF;
        end else if (push_ok_s) begin
            wrb_r   <= STB_ON;
            waddr_r <= wptr_r;
            din_r   <= PUSH_D;
        end else begin
            wrb_r <= STB_OFF;
        end
    end

    // Read strobe path and read-return valid pipeline (aligned to RDB low).
    always_ff @(posedge CLKS) begin
        if (!RSTB) begin
            rdb_r      <= STB_OFF;
            raddr_r    <= '0;
            vld_pipe_r <= '0;
        end else if (FLUSH) begin
            rdb_r      <= STB_OFF;
            vld_pipe_r <= '0;
        end else begin
            if (pop_ok_s) begin
                rdb_r   <= STB_ON;
                raddr_r <= rptr_r;
            end else begin
                rdb_r <= STB_OFF;
            end
            vld_pipe_r <= {vld_pipe_r[RD_LAT-1:0], pop_ok_s};
        end
    end

    // Sticky error flags; requests during flush are ignored.
    always_ff @(posedge CLKS) begin
        if (!RSTB) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (!FLUSH) begin
            if (PUSH && full_s)  ovf_r <= 1'b1;
            if (POP && empty_s)  udf_r <= 1'b1;
        end
    end

    assign WADDR   = waddr_r;
    assign WRB     = wrb_r;
    assign DIn     = din_r;
    assign RADDR   = raddr_r;
    assign RDB     = rdb_r;
    assign COUNT   = count_r;
    assign FULL    = full_s;
    assign EMPTY   = empty_s;
    assign OVF     = ovf_r;
    assign UDF     = udf_r;
    assign POP_VLD = vld_pipe_r[RD_LAT];
    assign POP_D   = POP_VLD ? DO : {DW{1'b0}};

endmodule

// File: tb/tb_ramblock_fifo_ctrl.sv
// Bench for ramblock_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_ramblock_fifo_ctrl;

    localparam int RD_LAT = 1;

    logic       CLKS = 1'b0;
    logic       RSTB, PUSH, POP, FLUSH;
    logic [8:0] PUSH_D;
    logic [8:0] TH;
    logic [7:0] WADDR, RADDR;
    logic       WRB, RDB;
    logic [8:0] DIn, ram_do, POP_D;
    logic       POP_VLD, FULL, EMPTY, EQTH, GEQTH, OVF, UDF;
    logic [8:0] COUNT;

    ramblock_fifo_ctrl #(.RD_LAT(RD_LAT)) dut (
        .CLKS(CLKS), .RSTB(RSTB), .PUSH(PUSH), .PUSH_D(PUSH_D), .POP(POP),
        .FLUSH(FLUSH), .TH(TH), .WADDR(WADDR), .WRB(WRB), .DIn(DIn),
        .RADDR(RADDR), .RDB(RDB), .DO(ram_do), .POP_D(POP_D), .POP_VLD(POP_VLD),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .EQTH(EQTH), .GEQTH(GEQTH),
        .OVF(OVF), .UDF(UDF)
    );

    always #5 CLKS = ~CLKS;

    // Behavioural 256x9 RAM, one-cycle synchronous read.
    logic [8:0] mem [0:255];
    always @(posedge CLKS) begin
        if (!WRB) mem[WADDR] <= DIn;
        if (!RDB) ram_do <= mem[RADDR];
    end

    // Reference model state
    logic [8:0] q[$];
    int         ret_cyc[$];
    logic [8:0] ret_dat[$];
    int         wp, rp, cyc;
    logic       e_wrb, e_rdb, e_ovf, e_udf;
    logic [7:0] e_waddr, e_raddr;
    logic [8:0] e_din;
    bit         chk_en;
    int         n_checks, n_errors;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check_val("count", COUNT, sz);
        check_val("full",  FULL,  sz == 256);
        check_val("empty", EMPTY, sz == 0);
        check_val("eqth",  EQTH,  sz == int'(TH));
        check_val("geqth", GEQTH, sz >= int'(TH));
        check_val("ovf",   OVF,   e_ovf);
        check_val("udf",   UDF,   e_udf);
        check_val("wrb",   WRB,   e_wrb);
        check_val("waddr", WADDR, e_waddr);
        check_val("din",   DIn,   e_din);
        check_val("rdb",   RDB,   e_rdb);
        check_val("raddr", RADDR, e_raddr);
        if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
            check_val("pop_vld", POP_VLD, 1);
            check_val("pop_d",   POP_D,   ret_dat[0]);
            void'(ret_cyc.pop_front());
            void'(ret_dat.pop_front());
        end else begin
            check_val("pop_vld", POP_VLD, 0);
            check_val("pop_d",   POP_D,   0);
        end
    endtask

    // One clock: apply inputs, advance the model, then check mid-cycle.
    task automatic step(input logic p, input logic [8:0] d, input logic o,
                        input logic f, input logic r);
        bit full_b, empty_b;
        PUSH = p; PUSH_D = d; POP = o; FLUSH = f; RSTB = r;
        full_b  = (q.size() == 256);
        empty_b = (q.size() == 0);
        if (!r) begin
            q.delete(); ret_cyc.delete(); ret_dat.delete();
            wp = 0; rp = 0; e_ovf = 0; e_udf = 0;
            e_wrb = 1; e_rdb = 1; e_waddr = 0; e_raddr = 0; e_din = 0;
        end else if (f) begin
            q.delete(); ret_cyc.delete(); ret_dat.delete();
            wp = 0; rp = 0; e_wrb = 1; e_rdb = 1;
        end else begin
            if (p && full_b)  e_ovf = 1;
            if (o && empty_b) e_udf = 1;
            if (o && !empty_b) begin
                ret_dat.push_back(q.pop_front());
                ret_cyc.push_back(cyc + 1 + RD_LAT);
                e_raddr = 8'(rp); rp = (rp + 1) % 256; e_rdb = 0;
            end else e_rdb = 1;
            if (p && !full_b) begin
                q.push_back(d);
                e_waddr = 8'(wp); e_din = d; wp = (wp + 1) % 256; e_wrb = 0;
            end else e_wrb = 1;
        end
        @(posedge CLKS);
        cyc++;
        @(negedge CLKS);
        if (chk_en) check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; chk_en = 0;
        TH = 9'd0;
        @(negedge CLKS);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        chk_en = 1;
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);

        // Basic ordering
        step(1'b1, 9'h1A5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h0FF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h000, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Fill, overflow, pop+push while full, drain
        for (int i = 0; i < 256; i++) step(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h155, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h0AA, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Threshold
        TH = 9'd4;
        for (int i = 0; i < 5; i++) step(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Wrap with steady occupancy of 3
        TH = 9'd3;
        for (int i = 0; i < 3; i++) step(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 9'($urandom), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Pop on empty with simultaneous push: underflow, no fall-through
        step(1'b1, 9'h123, 1'b1, 1'b0, 1'b1);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Reset right after an accepted pop, then flush right after one
        step(1'b1, 9'h011, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h022, 1'b0, 1'b0, 1'b1);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 9'h044, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h055, 1'b0, 1'b0, 1'b1);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h066, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Randomized traffic with shifting push/pop bias
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 85 : 15;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 49) == 0) TH = 9'($urandom_range(0, 256));
                step(1'($urandom_range(0, 99) < pw), 9'($urandom),
                     1'($urandom_range(0, 99) < (100 - pw)),
                     1'($urandom_range(0, 299) == 0),
                     1'($urandom_range(0, 599) != 0));
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ramblock_fifo_ctrl.md
Name: ramblock_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences one 256x9 synchronous-write, synchronous-read RAM block as a first-in first-out queue.
- Owns the write and read pointers, occupancy count, status flags and active-low RAM strobes.
- Supplies WADDR/WRB/DIn and RADDR/RDB to the RAM and returns read data with a valid strobe.
- Sits between a producer/consumer pair and the RAM block wrapper, replacing the RAM's internal FIFO mode (fifo tied 0).

Parameters:
AW, 8, address width; RAM depth is 2**AW.
DW, 9, data width.
RD_LAT, 1, RAM read latency in cycles from the RDB-low sampling edge to DO valid; legal values 1..2.

Ports:
CLKS  in  1  clock; also drives the RAM's RCLKS and WCLKS.
RSTB  in  1  reset, synchronous, active-low.
PUSH  in  1  producer write request.
PUSH_D  in  DW  producer write data.
POP  in  1  consumer read request.
FLUSH  in  1  synchronous clear of pointers and count.
TH  in  AW+1  occupancy threshold.
WADDR  out  AW  RAM write address.
WRB  out  1  RAM write strobe, active-low.
DIn  out  DW  RAM write data.
RADDR  out  AW  RAM read address.
RDB  out  1  RAM read strobe, active-low.
DO  in  DW  RAM read data (DO1 of RAM block).
POP_D  out  DW  read data to consumer.
POP_VLD  out  1  POP_D valid, one-cycle pulse per accepted pop.
COUNT  out  AW+1  occupancy, range 0..256.
FULL, EMPTY, EQTH, GEQTH  out  1 each  status flags.
OVF, UDF  out  1 each  sticky overflow / underflow error flags.

Behaviour:
- Reset applies on any CLKS edge with RSTB=0:
  - wptr, rptr and COUNT go to 0.
  - WRB=1, RDB=1, WADDR/RADDR/DIn=0.
  - EMPTY=1, FULL=0, OVF=0, UDF=0, POP_VLD=0.
  - Read-valid pipeline is cleared, so in-flight reads are discarded and no POP_VLD follows.
- Push is accepted iff PUSH=1 and FULL=0. Pop is accepted iff POP=1 and EMPTY=0. Flags are evaluated from the registered state before the edge.
- PUSH=1 while FULL sets OVF. POP=1 while EMPTY sets UDF, including a simultaneous push into an empty FIFO (no fall-through). OVF/UDF clear only on reset.
- On an accepted push:
  - Registered outputs take WADDR<=wptr, DIn<=PUSH_D, WRB<=0 for exactly one cycle.
  - wptr increments modulo 2**AW (255 wraps to 0).
- On an accepted pop:
  - Registered outputs take RADDR<=rptr, RDB<=0 for one cycle.
  - rptr increments modulo 2**AW.
- Both strobe paths have identical one-cycle register delay. A word pushed in cycle k is written at the end of cycle k+1, so a pop accepted in cycle k+1 reads at the end of cycle k+2 and gets correct data.
- Read return for a pop accepted in cycle k:
  - RDB is low in cycle k+1.
  - POP_VLD=1 in cycle k+1+RD_LAT, with POP_D=DO (combinational pass-through, gated to 0 when POP_VLD=0).
  - Back-to-back pops give back-to-back POP_VLD.
- COUNT updates at the accepting edge:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
- Flags are combinational from COUNT:
  - FULL = COUNT==2**AW; EMPTY = COUNT==0.
  - EQTH = COUNT==TH; GEQTH = COUNT>=TH.
  - TH=0 gives GEQTH=1 always.
- FLUSH=1 (RSTB=1):
  - Clears wptr, rptr and COUNT, drops pending strobes (WRB=RDB=1) and clears the read-valid pipeline.
  - PUSH/POP in the same cycle are ignored and do not set OVF/UDF.
  - RAM contents are untouched.
- Reset has priority over FLUSH; FLUSH has priority over push/pop.

Decomposition:
- Package ramblock_fifo_pkg holds AW, DW, DEPTH=2**AW, the RD_LAT limits, and the strobe-level constants STB_ON=1'b0 / STB_OFF=1'b1.
- One sub-module, ramblock_fifo_flags: COUNT in plus TH in, giving FULL/EMPTY/EQTH/GEQTH out; purely combinational.
- Pointers, strobe registers and the valid pipeline stay in the top.

Test Plan:
- Reset then push 0x1A5, 0x0FF, 0x000 in consecutive cycles, idle 2, pop 3 in consecutive cycles -> WRB low at cycles 1..3 with WADDR 0,1,2; POP_D 0x1A5, 0x0FF, 0x000 on consecutive POP_VLD pulses starting 2 cycles after the first pop (RD_LAT=1); EMPTY=1 at end.
- Push 256 words -> FULL=1, COUNT=256; a 257th push sets OVF=1, causes no WRB pulse and leaves COUNT=256; then one pop+push in the same cycle -> push rejected because FULL was set before the edge, so COUNT=255.
- TH=4: push 4 -> EQTH=1, GEQTH=1 at COUNT=4; push 1 more -> EQTH=0, GEQTH=1; pop 2 -> GEQTH=0.
- Wrap: 300 push/pop pairs with a steady occupancy of 3 -> WADDR/RADDR wrap 255->0, data order preserved, COUNT stays 3.
- Pop on an empty FIFO with a simultaneous push -> UDF=1, no RDB pulse, COUNT=1, later pop returns the pushed word.
- Pop accepted, then RSTB=0 on the next edge (or FLUSH=1) -> no POP_VLD, COUNT=0, WRB=RDB=1, EMPTY=1.
